freq_gate_counter: RTL and testbench



---
 rtl/freq_gate_counter.sv | 156 +++++++++++++++
 tb/tb_freq_gate_counter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_gate_counter.sv
// Counts rising edges of an asynchronous input over back-to-back windows of CLKS_PER_GATE clocks.
// Latency: an input rise is counted 3 clocks later; results are published one clock after a window's last cycle.
// Backpressure: none; the consumer must take count_out/ovf in the cycle valid pulses.
//
// Optional build macro: FREQ_GATE_SAT_EN
//   defined   -> the edge counter saturates at all-ones on overflow
//   undefined -> the edge counter wraps modulo 2^COUNT_W
//   ovf is reported identically in both builds.
//
// Ports:
//   CLOCK     in   system clock, rising edge
//   clr       in   asynchronous active-high reset
//   enable    in   run request; low idles the block and discards a partial window
//   sig_in    in   asynchronous signal to measure
//   count_out out  edge count of the last completed window
//   ovf       out  last completed window saw more than 2^COUNT_W-1 edges
//   valid     out  one-cycle pulse when count_out/ovf update
module freq_gate_counter #(
    parameter int CLKS_PER_GATE = 50000000,
    parameter int COUNT_W       = 16
) (
    input  logic               CLOCK,
    input  logic               clr,
    input  logic               enable,
    input  logic               sig_in,
    output logic [COUNT_W-1:0] count_out,
    output logic               ovf,
    output logic               valid
);

    localparam int                 GATE_W    = $clog2(CLKS_PER_GATE);
    localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(CLKS_PER_GATE - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               sync1_q, sync2_q, sync3_q;
    logic [GATE_W-1:0]  gate_cnt_q, gate_cnt_d;
    logic [COUNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic               sticky_q, sticky_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               valid_q, valid_d;

    logic               edge_det;
    logic               edge_at_max;
    logic               terminal;
    logic [COUNT_W-1:0] edge_cnt_inc;

    // Two flops resolve metastability; the third gives the previous
    // synchronized level so a rise is seen for exactly one cycle.
    always_ff @(posedge CLOCK or posedge clr) begin
        if (clr) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign edge_det    = sync2_q & ~sync3_q;
    assign edge_at_max = edge_det & (edge_cnt_q == CNT_MAX);
    assign terminal    = (gate_cnt_q == GATE_LAST);

`ifdef FREQ_GATE_SAT_EN
    assign edge_cnt_inc = (edge_cnt_q == CNT_MAX) ? CNT_MAX : edge_cnt_q + COUNT_W'(1);
`else
    assign edge_cnt_inc = edge_cnt_q + COUNT_W'(1);
`endif

    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sticky_d   = sticky_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;

        case (state_q)
            IDLE: begin
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                sticky_d   = 1'b0;
                if (enable) begin
                    state_d = GATE;
                end
            end
            GATE: begin
                if (terminal) begin
                    // The edge arriving in the last cycle still belongs to
                    // this window, so it is folded into the published count.
                    count_d    = edge_det ? edge_cnt_inc : edge_cnt_q;
                    ovf_d      = sticky_q | edge_at_max;
                    valid_d    = 1'b1;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    sticky_d   = 1'b0;
                    // A window that reaches its last cycle always publishes,
                    // even if enable drops in that same cycle.
                    if (!enable) begin
                        state_d = IDLE;
                    end
                end else if (!enable) begin
                    state_d    = IDLE;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    sticky_d   = 1'b0;
                end else begin
                    gate_cnt_d = gate_cnt_q + GATE_W'(1);
                    if (edge_det) begin
                        edge_cnt_d = edge_cnt_inc;
                        if (edge_at_max) begin
                            sticky_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK or posedge clr) begin
        if (clr) begin
            state_q    <= IDLE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sticky_q   <= 1'b0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sticky_q   <= sticky_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
        end
    end

    assign count_out = count_q;
    assign ovf       = ovf_q;
    assign valid     = valid_q;

endmodule

// File: tb/tb_freq_gate_counter.sv
// Bench for freq_gate_counter: two instances (16-bit and 4-bit counters)
// share stimulus and are compared every cycle against a window-level model.
module tb_freq_gate_counter;

    localparam int N = 100;

`ifdef FREQ_GATE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        CLOCK  = 1'b0;
    logic        clr    = 1'b1;
    logic        enable = 1'b0;
    logic        sig_in = 1'b0;
    logic [15:0] count16;
    logic        ovf16, valid16;
    logic [3:0]  count4;
    logic        ovf4, valid4;

    freq_gate_counter #(.CLKS_PER_GATE(N), .COUNT_W(16)) dut16 (
        .CLOCK(CLOCK), .clr(clr), .enable(enable), .sig_in(sig_in),
        .count_out(count16), .ovf(ovf16), .valid(valid16)
    );

    freq_gate_counter #(.CLKS_PER_GATE(N), .COUNT_W(4)) dut4 (
        .CLOCK(CLOCK), .clr(clr), .enable(enable), .sig_in(sig_in),
        .count_out(count4), .ovf(ovf4), .valid(valid4)
    );

    always #5 CLOCK = ~CLOCK;

    int checks   = 0;
    int failures = 0;

    // Reference model state: sampled input history, window progress and
    // the values the outputs should show.
    bit sq[$];
    int ncyc   = 0;
    bit m_run  = 1'b0;
    int m_pos  = 0;
    int m_cnt  = 0;
    int e16    = 0;
    int e4     = 0;
    bit eo16   = 1'b0;
    bit eo4    = 1'b0;
    bit evalid = 1'b0;

    // Stimulus selection and directed expectations on published windows.
    int smode  = 0;
    int dmode  = 0;
    int skip_v = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pub(input int c, input int w);
        int lim;
        lim = (1 << w) - 1;
        if (SAT) return (c > lim) ? lim : c;
        return c % (1 << w);
    endfunction

    task automatic model_reset();
        sq = '{1'b0, 1'b0, 1'b0, 1'b0};
        m_run  = 1'b0;
        m_pos  = 0;
        m_cnt  = 0;
        e16    = 0;
        e4     = 0;
        eo16   = 1'b0;
        eo4    = 1'b0;
        evalid = 1'b0;
    endtask

    // Called right after a rising edge: an input level sampled at edge n
    // becomes a counted rise at edge n+2. A window spans the N edges that
    // follow the edge where enable was seen high.
    task automatic model_posedge();
        bit e;
        sq.push_front(sig_in);
        void'(sq.pop_back());
        e = sq[2] && !sq[3];
        ncyc++;
        evalid = 1'b0;
        if (!m_run) begin
            if (enable) begin
                m_run = 1'b1;
                m_pos = 0;
                m_cnt = 0;
            end
        end else begin
            m_pos++;
            m_cnt += int'(e);
            if (m_pos == N) begin
                e16    = pub(m_cnt, 16);
                e4     = pub(m_cnt, 4);
                eo16   = (m_cnt > 65535);
                eo4    = (m_cnt > 15);
                evalid = 1'b1;
                m_pos  = 0;
                m_cnt  = 0;
                if (!enable) m_run = 1'b0;
            end else if (!enable) begin
                m_run = 1'b0;
                m_pos = 0;
                m_cnt = 0;
            end
        end
    endtask

    function automatic logic sig_value();
        case (smode)
            1:       return ((ncyc % 10) < 5);
            2:       return ((ncyc % 4) < 2);
            // Rise placed so its counted edge lands on a window's last cycle.
            3:       return m_run && (((m_pos + 3) % N) < 50);
            4:       return 1'b1;
            5:       return 1'($urandom_range(0, 1));
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_outputs();
        chk("count16", count16, e16);
        chk("ovf16",   ovf16,   eo16);
        chk("valid16", valid16, evalid);
        chk("count4",  count4,  e4);
        chk("ovf4",    ovf4,    eo4);
        chk("valid4",  valid4,  evalid);
    endtask

    task automatic directed_check();
        if (skip_v > 0) begin
            skip_v--;
        end else begin
            case (dmode)
                1: begin
                    chk("sq10_count16", count16, 10);
                    chk("sq10_ovf16",   ovf16,   0);
                    chk("sq10_count4",  count4,  10);
                    chk("sq10_ovf4",    ovf4,    0);
                end
                2: begin
                    chk("sq4_count4",  count4,  SAT ? 15 : 9);
                    chk("sq4_ovf4",    ovf4,    1);
                    chk("sq4_count16", count16, 25);
                    chk("sq4_ovf16",   ovf16,   0);
                end
                3: begin
                    chk("const1_count16", count16, 0);
                    chk("const1_ovf16",   ovf16,   0);
                end
                4: begin
                    chk("term_edge_count16", count16, 1);
                    chk("term_edge_count4",  count4,  1);
                end
                default: ;
            endcase
        end
    endtask

    // One clock: drive at the falling edge, model at the rising edge,
    // compare at the next falling edge.
    task automatic cyc(input logic en);
        enable = en;
        sig_in = sig_value();
        @(posedge CLOCK);
        model_posedge();
        @(negedge CLOCK);
        check_outputs();
        if (valid16 === 1'b1) directed_check();
    endtask

    // Raise enable from idle and measure edges until valid is sampled high.
    task automatic restart_check(input string tag);
        int start;
        bit found;
        found = 1'b0;
        cyc(1'b1);
        start = ncyc;
        for (int i = 0; i < 2 * N && !found; i++) begin
            cyc(1'b1);
            if (valid16 === 1'b1) begin
                found = 1'b1;
                chk(tag, ncyc + 1 - start, N + 1);
            end
        end
        chk({tag, "_seen"}, found, 1);
    endtask

    initial begin
        model_reset();

        // Reset state, with sig_in held high from reset onwards.
        sig_in = 1'b1;
        #2;
        check_outputs();
        @(negedge CLOCK);
        clr = 1'b0;

        smode = 4; dmode = 3; skip_v = 0;
        repeat (5) cyc(1'b0);
        repeat (3 * N + 5) cyc(1'b1);

        // Square wave of period 10 with enable held.
        smode = 1; dmode = 1; skip_v = 1;
        repeat (6 * N) cyc(1'b1);

        // Enable dropped at gate count 50 for 20 cycles.
        for (int i = 0; i < 3 * N && !(m_run && m_pos == 50); i++) cyc(1'b1);
        repeat (20) cyc(1'b0);
        restart_check("en_restart_latency");
        repeat (N + 10) cyc(1'b1);

        // Period 4: overflow of the 4-bit instance, then back to period 10.
        smode = 2; dmode = 2; skip_v = 1;
        repeat (3 * N) cyc(1'b1);
        smode = 1; dmode = 1; skip_v = 1;
        repeat (2 * N + 10) cyc(1'b1);

        // Rise aligned so the counted edge hits the last cycle of each window.
        smode = 3; dmode = 4; skip_v = 1;
        repeat (4 * N) cyc(1'b1);

        // Asynchronous clear at gate count 40, away from any clock edge.
        smode = 1; dmode = 0; skip_v = 0;
        for (int i = 0; i < 3 * N && !(m_run && m_pos == 40); i++) cyc(1'b1);
        #2;
        clr = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge CLOCK);
        clr = 1'b0;
        repeat (3) cyc(1'b0);
        restart_check("clr_restart_latency");
        repeat (N) cyc(1'b1);

        // Random input and mostly-high random enable.
        smode = 5; dmode = 0;
        for (int i = 0; i < 1500; i++) cyc(($urandom_range(0, 19) != 0) ? 1'b1 : 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
